// File: rtl/stream_packer.sv
// Width up-converter: packs RATIO narrow valid/ready beats into one wide word,
// flushing a partial word early on in_last with per-slot keep flags.
module stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(RATIO):0]      fill
);

    localparam int CW = $clog2(RATIO);
    localparam int WW = DATA_WIDTH * RATIO;

    logic [CW-1:0]   cnt;
    logic [WW-1:0]   acc;
    logic [WW-1:0]   word_next;
    logic [RATIO-1:0] keep_next;
    logic            accept;
    logic            complete;
    logic            consume;

    // Ready looks only at the output register, never at the incoming beat.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt == CW'(RATIO - 1)));
    assign consume  = out_valid && out_ready;
    assign fill     = {1'b0, cnt};

    always_comb begin
        word_next = '0;
        keep_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) < cnt) begin
                word_next[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
            end else if (CW'(k) == cnt) begin
                word_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end else begin
                word_next[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
            keep_next[k] = (CW'(k) <= cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (complete) begin
                out_data  <= word_next;
                out_keep  <= keep_next;
                out_last  <= in_last;
                out_valid <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
            end else begin
                if (accept) begin
                    acc[cnt*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                    cnt                               <= cnt + CW'(1);
                end
                // Data is left in place after a consume; only valid drops.
                if (consume) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer (DATA_WIDTH=8, RATIO=4): vector table plus
// hand-written backpressure and mid-word reset sequences.
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill;

    int checks = 0;
    int errors = 0;

    stream_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        l;
        logic [7:0]  d;
        logic        ordy;
        logic        irdy;
        logic        ov;
        logic [31:0] od;
        logic [3:0]  ok;
        logic        ol;
        logic [2:0]  fl;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] got[$];

    function automatic void add(logic r, logic v, logic l, logic [7:0] d, logic ordy,
                                logic irdy, logic ov, logic [31:0] od, logic [3:0] ok,
                                logic ol, logic [2:0] fl);
        vec_t e;
        e.rst = r; e.v = v; e.l = l; e.d = d; e.ordy = ordy;
        e.irdy = irdy; e.ov = ov; e.od = od; e.ok = ok; e.ol = ol; e.fl = fl;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Records every handshake on the output, then advances one clock.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            done = (in_ready === 1'b1);
            tick();
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [31:0] od,
                           input logic [3:0] ok, input logic ol, input logic [2:0] fl);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, "_data"}, out_data, od);
        chk({tag, "_keep"}, {28'd0, out_keep}, {28'd0, ok});
        chk({tag, "_last"}, {31'd0, out_last}, {31'd0, ol});
        chk({tag, "_fill"}, {29'd0, fill}, {29'd0, fl});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_out("reset", 1'b0, 32'h0, 4'h0, 1'b0, 3'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // full words
        add(0,1,0,8'h11,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,0,8'h22,1, 1,0,32'h0,4'h0,0,3'd2);
        add(0,1,0,8'h33,1, 1,0,32'h0,4'h0,0,3'd3);
        add(0,1,0,8'h44,1, 1,1,32'h44332211,4'hf,0,3'd0);
        add(0,0,0,8'h00,1, 1,0,32'h0,4'h0,0,3'd0);
        // partial flush then a full word
        add(0,1,0,8'hAA,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,1,8'hBB,1, 1,1,32'h0000BBAA,4'h3,1,3'd0);
        add(0,1,0,8'h01,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,0,8'h02,1, 1,0,32'h0,4'h0,0,3'd2);
        add(0,1,0,8'h03,1, 1,0,32'h0,4'h0,0,3'd3);
        add(0,1,0,8'h04,1, 1,1,32'h04030201,4'hf,0,3'd0);
        // one-beat packet completing while the previous word is consumed
        add(0,1,1,8'h5A,1, 1,1,32'h0000005A,4'h1,1,3'd0);
        add(0,0,0,8'h00,1, 1,0,32'h0,4'h0,0,3'd0);
        // back-to-back at full rate
        add(0,1,0,8'h10,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,0,8'h11,1, 1,0,32'h0,4'h0,0,3'd2);
        add(0,1,0,8'h12,1, 1,0,32'h0,4'h0,0,3'd3);
        add(0,1,0,8'h13,1, 1,1,32'h13121110,4'hf,0,3'd0);
        add(0,1,0,8'h14,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,0,8'h15,1, 1,0,32'h0,4'h0,0,3'd2);
        add(0,1,0,8'h16,1, 1,0,32'h0,4'h0,0,3'd3);
        add(0,1,0,8'h17,1, 1,1,32'h17161514,4'hf,0,3'd0);
        add(0,1,0,8'h18,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,0,8'h19,1, 1,0,32'h0,4'h0,0,3'd2);
        add(0,1,0,8'h1A,1, 1,0,32'h0,4'h0,0,3'd3);
        add(0,1,0,8'h1B,1, 1,1,32'h1B1A1918,4'hf,0,3'd0);
        add(0,0,0,8'h00,1, 1,0,32'h0,4'h0,0,3'd0);
        // last/data without valid are ignored, including mid-word
        add(0,0,1,8'hFF,1, 1,0,32'h0,4'h0,0,3'd0);
        add(0,1,0,8'h77,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,0,1,8'hEE,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,1,8'h78,1, 1,1,32'h00007877,4'h3,1,3'd0);
        add(0,0,0,8'h00,1, 1,0,32'h0,4'h0,0,3'd0);
        // last on the fourth beat
        add(0,1,0,8'hC1,1, 1,0,32'h0,4'h0,0,3'd1);
        add(0,1,0,8'hC2,1, 1,0,32'h0,4'h0,0,3'd2);
        add(0,1,0,8'hC3,1, 1,0,32'h0,4'h0,0,3'd3);
        add(0,1,1,8'hC4,1, 1,1,32'hC4C3C2C1,4'hf,1,3'd0);
        add(0,0,0,8'h00,1, 1,0,32'h0,4'h0,0,3'd0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; in_valid = tbl[i].v; in_last = tbl[i].l;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].irdy});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
            chk($sformatf("vec%0d_fill", i), {29'd0, fill}, {29'd0, tbl[i].fl});
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
                chk($sformatf("vec%0d_out_keep", i), {28'd0, out_keep}, {28'd0, tbl[i].ok});
                chk($sformatf("vec%0d_out_last", i), {31'd0, out_last}, {31'd0, tbl[i].ol});
            end
        end

        // backpressure: first word held, input stalls, then both words drain in order
        got.delete();
        out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk_out("bp_first", 1'b1, 32'h04030201, 4'hf, 1'b0, 3'd0);
        in_valid = 1'b1; in_data = 8'h05; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            tick();
            chk_out($sformatf("bp_hold%0d", c), 1'b1, 32'h04030201, 4'hf, 1'b0, 3'd0);
        end
        out_ready = 1'b1;
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        in_valid = 1'b0;
        for (int t = 0; t < 10 && got.size() < 2; t++) tick();
        chk("bp_word_count", got.size(), 32'd2);
        if (got.size() >= 1) chk("bp_word0", got[0], 32'h04030201);
        if (got.size() >= 2) chk("bp_word1", got[1], 32'h08070605);

        // reset mid-word discards the partial word
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        chk("rst_pre_fill", {29'd0, fill}, 32'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("rst_mid", 1'b0, 32'h0, 4'h0, 1'b0, 3'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        send(8'h33, 1'b0);
        send(8'h34, 1'b0);
        send(8'h35, 1'b0);
        send(8'h36, 1'b0);
        in_valid = 1'b0;
        chk_out("rst_after", 1'b1, 32'h36353433, 4'hf, 1'b0, 3'd0);
        // reset while a word is held clears the output register
        rst = 1'b1;
        tick();
        chk_out("rst_held", 1'b0, 32'h0, 4'h0, 1'b0, 3'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Width up-converter that packs RATIO narrow valid/ready beats of DATA_WIDTH bits into one wide word of DATA_WIDTH*RATIO bits.
- Sits directly upstream of the stream FIFO; its output port connects straight to the FIFO's in_data/in_valid/in_ready, with the FIFO's DATA_WIDTH set to DATA_WIDTH*RATIO.
- Supports early flush of a partial word on in_last, with per-slot keep flags.

Parameters:
- DATA_WIDTH, 8, width of one input beat.
- RATIO, 4, input beats per output word; legal range is 2 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  DATA_WIDTH  input beat.
- in_valid  in  1  input beat valid.
- in_last  in  1  final beat of a packet; qualified by in_valid.
- in_ready  out  1  packer can accept a beat this cycle.
- out_data  out  DATA_WIDTH*RATIO  packed word; slot k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep  out  RATIO  bit k set when slot k holds a real beat.
- out_last  out  1  word closes a packet.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- fill  out  $clog2(RATIO)+1  number of beats held in the accumulator.

Behaviour:
- Handshakes:
  - An input beat is accepted when in_valid && in_ready.
  - An output word is consumed when out_valid && out_ready.
- Storage:
  - Accumulator register: RATIO slots plus a slot counter cnt, range 0..RATIO-1.
  - One output register holding out_data, out_keep and out_last.
- in_ready = !out_valid || out_ready.
  - Combinational from out_ready only; it never depends on in_valid or in_last.
  - A non-completing beat therefore stalls while the output register is blocked. This is accepted for simplicity.
- Slot ordering: the first beat of a word goes into slot 0 (LSBs), then slots fill in ascending order.
- Accepted beat, not completing (cnt < RATIO-1 and in_last=0):
  - Write in_data into slot cnt.
  - Increment cnt.
  - out_valid is unaffected by this beat.
- Accepted beat, completing (cnt == RATIO-1, or in_last=1):
  - On the same edge, load the output register:
    - slots 0..cnt-1 from the accumulator;
    - slot cnt from in_data;
    - all higher slots set to zero.
  - out_keep gets bits 0..cnt set, all higher bits clear.
  - out_last = in_last.
  - out_valid is set to 1.
  - Clear cnt and all accumulator slots to 0.
- Latency: out_valid rises on the edge that accepts the completing beat, i.e. the cycle after it is presented. Throughput is one input beat per cycle while out_ready=1.
- Output register hold: while out_valid=1 and out_ready=0, out_data, out_keep and out_last hold stable.
- Output register clear:
  - A word is consumed and no completing beat is accepted on the same edge: out_valid goes to 0; data holds its old value (don't-care).
  - Consume and completing accept on the same edge: the new word replaces the old one and out_valid stays 1, with no bubble.
- in_last with cnt == RATIO-1: produces a full word with out_keep all ones and out_last=1.
- in_last on the first beat (cnt=0): one-beat word, out_keep = 1 (slot 0 only), out_last=1.
- Partial words are emitted only on in_last; there is no timeout flush.
- fill = cnt, registered. It is never equal to RATIO.
- Reset (synchronous, active-high, may be asserted mid-word):
  - Cleared to 0: out_valid, out_data, out_keep, out_last, cnt, accumulator, fill.
  - Any partial word is discarded.
  - in_ready reads 1 during and after reset (follows from out_valid=0).
- in_last or in_data presented while in_valid=0 is ignored.

Test Plan:
- Full words: DATA_WIDTH=8, RATIO=4, out_ready=1; beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one word 0x44332211, out_keep=4'b1111, out_last=0; out_valid high for exactly one cycle, the cycle after the 0x44 beat.
- Partial flush: beats 0xAA, 0xBB(in_last=1) -> word 0x0000BBAA, out_keep=4'b0011, out_last=1; afterwards fill=0. Next beats 0x01..0x04 -> 0x04030201.
- Backpressure: out_ready=0; stream 8 beats 0x01..0x08 -> first word 0x04030201 held stable with out_valid=1; in_ready=0 from the cycle after the 4th beat is accepted. Raise out_ready -> both words arrive in order, no beats lost or duplicated.
- Back-to-back at full rate: out_ready=1, 12 continuous beats -> 3 words on cycles 4, 8 and 12; in_ready never drops. Include a case where consume and completing accept coincide -> no bubble on out_valid.
- One-beat packet: single beat 0x5A with in_last=1 at cnt=0 -> word 0x0000005A, out_keep=4'b0001, out_last=1.
- Reset mid-word: accept 0x11, 0x22, assert rst for one cycle, then send 0x33..0x36 -> first word is 0x36353433; 0x11/0x22 never appear; all outputs are 0 during reset.
